// File: rtl/flight_pkg.sv
// Shared flight-control constants: default rate width, throttle ceiling,
// button bit positions and the handshake state encoding.
package flight_pkg;
   localparam int INPUT_WIDTH  = 8;
   localparam int THROTTLE_MAX = 100;
   localparam int NUM_BTNS     = 6;

   localparam int BTN_PITCH_UP = 0;
   localparam int BTN_PITCH_DN = 1;
   localparam int BTN_ROLL_R   = 2;
   localparam int BTN_ROLL_L   = 3;
   localparam int BTN_THR_UP   = 4;
   localparam int BTN_THR_DN   = 5;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_READY = 1'b1
   } hs_state_e;
endpackage

// File: rtl/pilot_input_debounce.sv
// Two-flop synchroniser plus stability counter for one raw active-low button;
// o_level is the debounced active-high level.
module debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn_n,
   output logic o_level
);
   import flight_pkg::*;

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic [CW-1:0] r_cnt;
   logic          w_pressed;

   assign w_pressed = ~r_sync2;

   // Level flips only after DEBOUNCE_CYCLES+1 consecutive disagreeing samples.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else begin
         r_sync1 <= i_btn_n;
         r_sync2 <= r_sync1;
         if (w_pressed == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
            r_level <= w_pressed;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_level = r_level;
endmodule

// File: rtl/pilot_input.sv
// Pilot command source: debounced buttons, ramped pitch/roll rates, stepped throttle,
// snapshots served over request_input/input_ready. PILOT_INPUT_AUTOCENTER_EN recentres released axes.
module pilot_input #(
   parameter int INPUT_WIDTH     = flight_pkg::INPUT_WIDTH,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int RAMP_TICKS      = 2500000,
   parameter int RATE_STEP       = 5,
   parameter int RATE_MAX        = 45,
   parameter int THROTTLE_STEP   = 10,
   parameter int THROTTLE_RESET  = 50
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [5:0]                    btn_n,
   input  logic                          request_input,
   output logic                          input_ready,
   output logic signed [INPUT_WIDTH-1:0] pitch_change,
   output logic signed [INPUT_WIDTH-1:0] roll_change,
   output logic [INPUT_WIDTH:0]          throttle,
   output logic [5:0]                    btn_state
);
   import flight_pkg::*;

   localparam int AW  = INPUT_WIDTH + 2;
   localparam int TW  = INPUT_WIDTH + 1;
   localparam int TCW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
`ifdef PILOT_INPUT_AUTOCENTER_EN
   localparam bit AUTOCENTER = 1'b1;
`else
   localparam bit AUTOCENTER = 1'b0;
`endif
   localparam logic signed [AW-1:0] RATE_POS = AW'(RATE_MAX);
   localparam logic signed [AW-1:0] RATE_NEG = -AW'(RATE_MAX);
   localparam logic signed [AW-1:0] THR_TOP  = AW'(THROTTLE_MAX);
   localparam logic [TW-1:0]        THR_RST  = TW'(THROTTLE_RESET);

   function automatic logic signed [AW-1:0] axis_target(input logic pos, input logic neg,
                                                         input logic signed [AW-1:0] live);
      if (pos && !neg) return RATE_POS;
      if (neg && !pos) return RATE_NEG;
      return AUTOCENTER ? '0 : live;
   endfunction

   function automatic logic signed [AW-1:0] axis_step(input logic signed [AW-1:0] live,
                                                       input logic signed [AW-1:0] tgt);
      logic signed [AW-1:0] nxt;
      nxt = live;
      if (live < tgt) begin
         nxt = live + AW'(RATE_STEP);
         if (nxt > tgt) nxt = tgt;
      end else if (live > tgt) begin
         nxt = live - AW'(RATE_STEP);
         if (nxt < tgt) nxt = tgt;
      end
      return nxt;
   endfunction

   function automatic logic signed [INPUT_WIDTH-1:0] sat_rate(input logic signed [AW-1:0] v);
      logic signed [AW-1:0] c;
      c = v;
      if (c > RATE_POS)      c = RATE_POS;
      else if (c < RATE_NEG) c = RATE_NEG;
      return c[INPUT_WIDTH-1:0];
   endfunction

   function automatic logic [TW-1:0] thr_step(input logic [TW-1:0] thr, input logic up,
                                              input logic dn);
      logic signed [AW-1:0] v;
      v = $signed({1'b0, thr});
      if (up && !dn)      v = v + AW'(THROTTLE_STEP);
      else if (dn && !up) v = v - AW'(THROTTLE_STEP);
      if (v > THR_TOP)    v = THR_TOP;
      else if (v < 0)     v = '0;
      return v[TW-1:0];
   endfunction

   logic [NUM_BTNS-1:0]          w_btn;
   logic [TCW-1:0]               r_tick_cnt;
   logic                         w_tick;
   logic signed [INPUT_WIDTH-1:0] r_pitch_live;
   logic signed [INPUT_WIDTH-1:0] r_roll_live;
   logic signed [AW-1:0]         w_pitch_ext;
   logic signed [AW-1:0]         w_roll_ext;
   logic [TW-1:0]                r_thr_live;
   logic [1:0]                   r_thr_prev;
   logic                         w_thr_up_rise;
   logic                         w_thr_dn_rise;
   hs_state_e                    r_state;
   hs_state_e                    w_next;
   logic                         w_load;
   logic signed [INPUT_WIDTH-1:0] r_pitch_out;
   logic signed [INPUT_WIDTH-1:0] r_roll_out;
   logic [TW-1:0]                r_thr_out;

   for (genvar g = 0; g < NUM_BTNS; g++) begin : g_db
      debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .i_clk   (clk),
         .i_rst_n (reset_n),
         .i_btn_n (btn_n[g]),
         .o_level (w_btn[g])
      );
   end

   assign w_tick = (r_tick_cnt == TCW'(RAMP_TICKS - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_tick_cnt <= '0;
      else          r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TCW'(1);
   end

   assign w_pitch_ext   = AW'(r_pitch_live);
   assign w_roll_ext    = AW'(r_roll_live);
   assign w_thr_up_rise = w_btn[BTN_THR_UP] & ~r_thr_prev[0];
   assign w_thr_dn_rise = w_btn[BTN_THR_DN] & ~r_thr_prev[1];

   // Live state: axes move only on the ramp tick, throttle on debounced press edges.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pitch_live <= '0;
         r_roll_live  <= '0;
         r_thr_live   <= THR_RST;
         r_thr_prev   <= '0;
      end else begin
         r_thr_prev <= {w_btn[BTN_THR_DN], w_btn[BTN_THR_UP]};
         r_thr_live <= thr_step(r_thr_live, w_thr_up_rise, w_thr_dn_rise);
         if (w_tick) begin
            r_pitch_live <= sat_rate(axis_step(w_pitch_ext,
               axis_target(w_btn[BTN_PITCH_UP], w_btn[BTN_PITCH_DN], w_pitch_ext)));
            r_roll_live  <= sat_rate(axis_step(w_roll_ext,
               axis_target(w_btn[BTN_ROLL_R], w_btn[BTN_ROLL_L], w_roll_ext)));
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (request_input) begin
               w_next = ST_READY;
               w_load = 1'b1;
            end
         end
         ST_READY: begin
            if (!request_input) w_next = ST_IDLE;
         end
      endcase
   end

   // Snapshot registers capture the pre-edge live values on IDLE->READY only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pitch_out <= '0;
         r_roll_out  <= '0;
         r_thr_out   <= THR_RST;
      end else if (w_load) begin
         r_pitch_out <= r_pitch_live;
         r_roll_out  <= r_roll_live;
         r_thr_out   <= r_thr_live;
      end
   end

   assign input_ready  = (r_state == ST_READY);
   assign pitch_change = r_pitch_out;
   assign roll_change  = r_roll_out;
   assign throttle     = r_thr_out;
   assign btn_state    = w_btn;
endmodule

// File: tb/tb_pilot_input.sv
// Bench for pilot_input: directed steps plus random button/request traffic,
// compared every cycle with a behavioural model of the pilot-command rules.
module tb_pilot_input;
   localparam int IW = 8;
   localparam int DB = 4;
   localparam int RT = 8;
   localparam int RS = 5;
   localparam int RM = 45;
   localparam int TS = 10;
   localparam int TR = 50;
`ifdef PILOT_INPUT_AUTOCENTER_EN
   localparam bit AC = 1'b1;
`else
   localparam bit AC = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 request_input = 1'b0;
   logic [5:0]           btn_n = 6'h3f;
   logic                 input_ready;
   logic signed [IW-1:0] pitch_change;
   logic signed [IW-1:0] roll_change;
   logic [IW:0]          throttle;
   logic [5:0]           btn_state;

   int n_pass = 0;
   int n_fail = 0;
   int n_chk  = 0;
   int lat;
   int exp_p;
   int dur;

   always #5 clk = ~clk;

   pilot_input #(
      .INPUT_WIDTH(IW), .DEBOUNCE_CYCLES(DB), .RAMP_TICKS(RT), .RATE_STEP(RS),
      .RATE_MAX(RM), .THROTTLE_STEP(TS), .THROTTLE_RESET(TR)
   ) dut (
      .clk(clk), .reset_n(reset_n), .btn_n(btn_n), .request_input(request_input),
      .input_ready(input_ready), .pitch_change(pitch_change), .roll_change(roll_change),
      .throttle(throttle), .btn_state(btn_state)
   );

   // Reference model: a button's debounced level becomes v once the raw input,
   // seen two cycles late, has read v for DB+1 cycles in a row.
   logic [5:0] m_hist [0:DB+1];
   logic [5:0] m_lvl, m_lvl_d;
   int         m_cyc, m_pl, m_rl, m_thr, m_p, m_r, m_t;
   bit         m_rdy;

   function automatic logic [5:0] next_lvl();
      logic [5:0] all1, all0;
      all1 = '1;
      all0 = '1;
      for (int j = 1; j <= DB + 1; j++) begin
         all1 &= m_hist[j];
         all0 &= ~m_hist[j];
      end
      return (m_lvl | all1) & ~all0;
   endfunction

   function automatic int ramp(input int live, input bit pos, input bit neg);
      int tgt;
      if (pos && !neg)      tgt = RM;
      else if (neg && !pos) tgt = -RM;
      else if (AC)          tgt = 0;
      else                  return live;
      if (live < tgt) return (live + RS > tgt) ? tgt : live + RS;
      if (live > tgt) return (live - RS < tgt) ? tgt : live - RS;
      return live;
   endfunction

   function automatic int thr_next(input int thr, input bit up, input bit dn);
      if (up && !dn) return (thr + TS > 100) ? 100 : thr + TS;
      if (dn && !up) return (thr - TS < 0) ? 0 : thr - TS;
      return thr;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j <= DB + 1; j++) m_hist[j] <= '0;
         m_lvl   <= '0;
         m_lvl_d <= '0;
         m_cyc   <= 0;
         m_pl    <= 0;
         m_rl    <= 0;
         m_thr   <= TR;
         m_rdy   <= 1'b0;
         m_p     <= 0;
         m_r     <= 0;
         m_t     <= TR;
      end else begin
         m_hist[0] <= ~btn_n;
         for (int j = 1; j <= DB + 1; j++) m_hist[j] <= m_hist[j-1];
         m_lvl   <= next_lvl();
         m_lvl_d <= m_lvl;
         m_cyc   <= m_cyc + 1;
         if ((m_cyc + 1) % RT == 0) begin
            m_pl <= ramp(m_pl, m_lvl[0], m_lvl[1]);
            m_rl <= ramp(m_rl, m_lvl[2], m_lvl[3]);
         end
         m_thr <= thr_next(m_thr, m_lvl[4] & ~m_lvl_d[4], m_lvl[5] & ~m_lvl_d[5]);
         if (!m_rdy && request_input) begin
            m_rdy <= 1'b1;
            m_p   <= m_pl;
            m_r   <= m_rl;
            m_t   <= m_thr;
         end else if (m_rdy && !request_input) begin
            m_rdy <= 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check_all();
      chk("ready", input_ready, m_rdy);
      chk("pitch", pitch_change, m_p);
      chk("roll", roll_change, m_r);
      chk("throttle", throttle, m_t);
      chk("btn_state", btn_state, m_lvl);
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check_all();
      end
   endtask

   task automatic snap();
      request_input = 1'b1;
      cyc(1);
      chk("snap_ready", input_ready, 1);
      request_input = 1'b0;
      cyc(1);
   endtask

   task automatic press(input logic [5:0] mask);
      btn_n = btn_n & ~mask;
      cyc(8);
      btn_n = btn_n | mask;
      cyc(8);
   endtask

   initial begin
      #12;
      chk("rst_ready", input_ready, 0);
      chk("rst_pitch", pitch_change, 0);
      chk("rst_roll", roll_change, 0);
      chk("rst_throttle", throttle, TR);
      chk("rst_btn", btn_state, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc(2);

      request_input = 1'b1;
      cyc(1);
      chk("first_ready", input_ready, 1);
      chk("first_throttle", throttle, 50);
      chk("first_pitch", pitch_change, 0);
      chk("first_roll", roll_change, 0);
      request_input = 1'b0;
      cyc(1);
      chk("first_idle", input_ready, 0);

      btn_n[0] = 1'b0;
      cyc(3);
      btn_n[0] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         chk("glitch_btn", btn_state, 0);
      end

      btn_n[0] = 1'b0;
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         cyc(1);
         if (lat == 0 && btn_state[0]) lat = i;
      end
      chk("debounce_latency", lat, 7);

      for (int t = 0; t < 80; t++) begin
         request_input = 1'b1;
         cyc(1);
         request_input = 1'b0;
         cyc(7);
      end
      snap();
      chk("pitch_clamp", pitch_change, 45);
      btn_n[0] = 1'b1;
      cyc(200);
      snap();
      chk("pitch_release", pitch_change, AC ? 0 : 45);

      btn_n[3] = 1'b0;
      cyc(100);
      snap();
      chk("roll_left_clamp", roll_change, -45);
      btn_n[3] = 1'b1;
      cyc(20);

      for (int i = 0; i < 6; i++) press(6'b010000);
      snap();
      chk("thr_top", throttle, 100);
      for (int i = 0; i < 12; i++) press(6'b100000);
      snap();
      chk("thr_bottom", throttle, 0);
      press(6'b010000);
      press(6'b110000);
      snap();
      chk("thr_simultaneous", throttle, 10);

      btn_n[1] = 1'b0;
      cyc(10);
      request_input = 1'b1;
      cyc(1);
      exp_p = m_p;
      for (int i = 0; i < 60; i++) begin
         cyc(1);
         chk("frozen_pitch", pitch_change, exp_p);
      end
      request_input = 1'b0;
      cyc(1);
      request_input = 1'b1;
      cyc(1);
      chk("refresh_ready", input_ready, 1);
      chk("refresh_moved", (pitch_change < exp_p) ? 1 : 0, 1);
      request_input = 1'b0;
      btn_n[1] = 1'b1;
      cyc(20);

      request_input = 1'b1;
      cyc(1);
      chk("pre_reset_ready", input_ready, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_ready", input_ready, 0);
      chk("async_rst_throttle", throttle, TR);
      chk("async_rst_pitch", pitch_change, 0);
      chk("async_rst_roll", roll_change, 0);
      chk("async_rst_btn", btn_state, 0);
      request_input = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc(2);
      request_input = 1'b1;
      cyc(1);
      chk("post_rst_ready", input_ready, 1);
      chk("post_rst_throttle", throttle, TR);
      request_input = 1'b0;
      cyc(1);

      for (int s = 0; s < 40; s++) begin
         btn_n = 6'($urandom) | 6'($urandom);
         dur = $urandom_range(2, 40);
         for (int i = 0; i < dur; i++) begin
            if ($urandom_range(0, 3) == 0) request_input = ~request_input;
            cyc(1);
         end
      end
      request_input = 1'b0;
      btn_n = 6'h3f;
      cyc(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
